// File: rtl/warp_issue_unit_if.sv
// Instruction-in and issue-out handshake bundle for the warp issue stage.
// master drives instructions and consumes issues; slave is the issue unit.
interface warp_issue_unit_if #(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_opcode;
  logic [4:0]            out_dst;
  logic [4:0]            out_src1;
  logic [4:0]            out_src2;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [NUM_LANES-1:0]  out_mask;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_opcode, out_dst, out_src1, out_src2, out_imm, out_mask
  );

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_opcode, out_dst, out_src1, out_src2, out_imm, out_mask
  );
endinterface

// File: rtl/warp_issue_unit.sv
// Decode-and-issue stage: one-entry holding register, per-register write
// scoreboard with RAW/WAW/in-flight-limit stalls, lane-mask tagging, flush.
module warp_issue_unit #(
  parameter int unsigned NUM_LANES     = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_FILE_SIZE = 32,
  parameter int unsigned MAX_PENDING   = 4,
  localparam int unsigned PW           = $clog2(MAX_PENDING + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  warp_issue_unit_if.slave     io,
  input  logic                 mask_wr_i,
  input  logic [NUM_LANES-1:0] mask_in_i,
  input  logic                 wb_valid_i,
  input  logic [4:0]           wb_dst_i,
  input  logic                 flush_i,
  output logic                 err_illegal_o,
  output logic [PW-1:0]        pending_count_o,
  output logic                 busy_o
);

  localparam int unsigned RW = $clog2(REG_FILE_SIZE);

  typedef struct packed {
    logic                  valid;
    logic [3:0]            opcode;
    logic [4:0]            dst;
    logic [4:0]            src1;
    logic [4:0]            src2;
    logic [DATA_WIDTH-1:0] imm;
    logic [NUM_LANES-1:0]  mask;
    logic                  rd_src2;
    logic                  rd_dst;
    logic                  wr;
  } hold_t;

  hold_t                    hold_q, hold_d;
  logic [REG_FILE_SIZE-1:0] sb_q, sb_d;
  logic [PW-1:0]            pend_q, pend_d;
  logic [NUM_LANES-1:0]     mask_q, mask_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;

  logic [3:0] dec_op;
  logic [4:0] dec_dst, dec_src1, dec_src2;
  logic       dec_rd_src2, dec_rd_dst, dec_wr, dec_legal;
  logic       hazard, out_valid, in_ready, issue, accept, sb_set, wb_hit;

  function automatic logic in_range(input logic [4:0] r);
    return 32'(r) < REG_FILE_SIZE;
  endfunction

  // Field extraction and opcode class decode of the incoming instruction
  always_comb begin
    dec_op      = io.in_inst[31:28];
    dec_dst     = io.in_inst[27:23];
    dec_src1    = io.in_inst[22:18];
    dec_src2    = io.in_inst[17:13];
    dec_wr      = dec_op <= 4'd5;
    dec_rd_src2 = dec_op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
    dec_rd_dst  = dec_op == 4'd2;
    dec_legal   = (dec_op <= 4'd6) && in_range(dec_src1)
                  && (!dec_rd_src2 || in_range(dec_src2))
                  && (!dec_wr || in_range(dec_dst));
  end

  // Hazard check and handshakes; src1 is read by every legal class
  always_comb begin
    hazard    = sb_q[hold_q.src1[RW-1:0]]
                || (hold_q.rd_src2 && sb_q[hold_q.src2[RW-1:0]])
                || ((hold_q.rd_dst || hold_q.wr) && sb_q[hold_q.dst[RW-1:0]])
                || (hold_q.wr && (pend_q == PW'(MAX_PENDING)));
    out_valid = hold_q.valid && !hazard;
    issue     = out_valid && io.out_ready;
    in_ready  = !flush_i && (!hold_q.valid || issue);
    accept    = io.in_valid && in_ready;
    sb_set    = issue && hold_q.wr;
    // A writeback that coincides with the issue of its own register counts as a retire
    wb_hit    = wb_valid_i && in_range(wb_dst_i)
                && (sb_q[wb_dst_i[RW-1:0]] || (sb_set && (hold_q.dst == wb_dst_i)));
  end

  always_comb begin
    hold_d = hold_q;
    sb_d   = sb_q;
    pend_d = pend_q;
    mask_d = mask_q;
    err_d  = err_q;
    if (mask_wr_i) mask_d = mask_in_i;
    if (accept && !dec_legal) err_d = 1'b1;
    if (flush_i) begin
      hold_d.valid = 1'b0;
      sb_d         = '0;
      pend_d       = '0;
    end else begin
      if (issue) hold_d.valid = 1'b0;
      if (accept && dec_legal) begin
        hold_d.valid   = 1'b1;
        hold_d.opcode  = dec_op;
        hold_d.dst     = dec_dst;
        hold_d.src1    = dec_src1;
        hold_d.src2    = dec_src2;
        hold_d.imm     = DATA_WIDTH'($signed(io.in_inst[12:0]));
        hold_d.mask    = mask_q;
        hold_d.rd_src2 = dec_rd_src2;
        hold_d.rd_dst  = dec_rd_dst;
        hold_d.wr      = dec_wr;
      end
      if (wb_hit) sb_d[wb_dst_i[RW-1:0]] = 1'b0;
      if (sb_set) sb_d[hold_q.dst[RW-1:0]] = 1'b1;
      if (sb_set && !wb_hit) pend_d = pend_q + PW'(1);
      else if (wb_hit && !sb_set && (pend_q != '0)) pend_d = pend_q - PW'(1);
    end
    busy_d = hold_d.valid || (pend_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      sb_q   <= '0;
      pend_q <= '0;
      mask_q <= '1;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      sb_q   <= sb_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    io.in_ready     = in_ready;
    io.out_valid    = out_valid;
    io.out_opcode   = hold_q.opcode;
    io.out_dst      = hold_q.dst;
    io.out_src1     = hold_q.src1;
    io.out_src2     = hold_q.src2;
    io.out_imm      = hold_q.imm;
    io.out_mask     = hold_q.mask;
    err_illegal_o   = err_q;
    pending_count_o = pend_q;
    busy_o          = busy_q;
  end

endmodule

// File: tb/tb_warp_issue_unit.sv
// Bench for warp_issue_unit: decode table, directed corner sequences, and a
// randomized run against a queue/array-based reference model.
module tb_warp_issue_unit;
  localparam int unsigned NL  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned RFS = 32;
  localparam int unsigned MP  = 4;
  localparam int unsigned PW  = $clog2(MP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          mask_wr;
  logic [NL-1:0] mask_in;
  logic          wb_valid;
  logic [4:0]    wb_dst;
  logic          flush;
  logic          err_illegal;
  logic [PW-1:0] pending_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  warp_issue_unit_if #(.NUM_LANES(NL), .DATA_WIDTH(DW)) bus ();

  warp_issue_unit #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .REG_FILE_SIZE(RFS), .MAX_PENDING(MP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .io(bus),
    .mask_wr_i(mask_wr), .mask_in_i(mask_in),
    .wb_valid_i(wb_valid), .wb_dst_i(wb_dst), .flush_i(flush),
    .err_illegal_o(err_illegal), .pending_count_o(pending_count), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] inst;
    logic        legal;
    logic [3:0]  op;
    logic [4:0]  dst, s1, s2;
    logic [31:0] imm;
    logic        wr;
  } vec_t;

  // Reference model state
  int m_op, m_dst, m_s1, m_s2, m_pend;
  bit m_hv, m_err;
  bit m_sb[32];
  logic [31:0] m_imm;
  logic [NL-1:0] m_mask, m_cmask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.out_ready = 1'b1;
    mask_wr = 1'b0; mask_in = '0; wb_valid = 1'b0; wb_dst = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    go(); go();
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] inst);
    bus.in_valid = 1'b1; bus.in_inst = inst;
    go();
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] enc(input int op, input int d, input int s1, input int s2, input int imm);
    return {4'(op), 5'(d), 5'(s1), 5'(s2), 13'(imm)};
  endfunction

  function automatic bit m_writer(input int op);
    return op <= 5;
  endfunction

  function automatic bit m_hazard();
    int rd[$];
    rd = {m_s1};
    if (m_op inside {0, 1, 2, 3, 6}) rd.push_back(m_s2);
    if (m_op == 2) rd.push_back(m_dst);
    foreach (rd[i]) if (m_sb[rd[i]]) return 1'b1;
    if (m_writer(m_op) && (m_sb[m_dst] || m_pend == int'(MP))) return 1'b1;
    return 1'b0;
  endfunction

  vec_t vt[9];

  initial begin
    bit err_exp;
    rst = 1'b1;
    idle();

    vt[0] = '{32'h01844000,             1, 4'd0, 5'd3,  5'd1,  5'd2,  32'h00000000, 1};
    vt[1] = '{{4'd1, 5'd31, 5'd30, 5'd29, 13'd1},     1, 4'd1, 5'd31, 5'd30, 5'd29, 32'h00000001, 1};
    vt[2] = '{{4'd2, 5'd4, 5'd5, 5'd6, 13'h1000},     1, 4'd2, 5'd4,  5'd5,  5'd6,  32'hFFFFF000, 1};
    vt[3] = '{{4'd3, 5'd0, 5'd7, 5'd8, 13'h0FFF},     1, 4'd3, 5'd0,  5'd7,  5'd8,  32'h00000FFF, 1};
    vt[4] = '{{4'd4, 5'd9, 5'd10, 5'd11, 13'h1FFE},   1, 4'd4, 5'd9,  5'd10, 5'd11, 32'hFFFFFFFE, 1};
    vt[5] = '{{4'd5, 5'd12, 5'd13, 5'd0, 13'd5},      1, 4'd5, 5'd12, 5'd13, 5'd0,  32'h00000005, 1};
    vt[6] = '{{4'd6, 5'd16, 5'd14, 5'd15, 13'h1555},  1, 4'd6, 5'd16, 5'd14, 5'd15, 32'hFFFFF555, 0};
    vt[7] = '{{4'd7, 5'd1, 5'd2, 5'd3, 13'd0},        0, 4'd0, 5'd0,  5'd0,  5'd0,  32'h0, 0};
    vt[8] = '{{4'd15, 5'd1, 5'd2, 5'd3, 13'd0},       0, 4'd0, 5'd0,  5'd0,  5'd0,  32'h0, 0};

    // Reset state
    do_reset();
    mid();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_pending", pending_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_out_mask", bus.out_mask, 0);
    chk("rst_out_imm", bus.out_imm, 0);

    // ADD r3,r1,r2 then a WAW on r3
    bus.in_valid = 1'b1; bus.in_inst = 32'h01844000;
    go(); bus.in_valid = 1'b0; mid();
    chk("add_valid", bus.out_valid, 1);
    chk("add_op", bus.out_opcode, 0);
    chk("add_dst", bus.out_dst, 3);
    chk("add_src1", bus.out_src1, 1);
    chk("add_src2", bus.out_src2, 2);
    chk("add_imm", bus.out_imm, 0);
    chk("add_mask", bus.out_mask, 8'hFF);
    go(); mid();
    chk("add_pending", pending_count, 1);
    chk("add_busy", busy, 1);
    send(enc(0, 3, 4, 5, 0)); mid();
    chk("waw_stall0", bus.out_valid, 0);
    go(); mid();
    chk("waw_stall1", bus.out_valid, 0);
    wb_valid = 1'b1; wb_dst = 5'd3;
    go(); wb_valid = 1'b0; mid();
    chk("waw_release", bus.out_valid, 1);
    chk("waw_pending", pending_count, 0);
    go(); mid();
    chk("waw_reissue_pending", pending_count, 1);

    // RAW: MUL r5 <- r1,r2 ; RELU r6 <- r5
    do_reset();
    bus.in_valid = 1'b1; bus.in_inst = enc(1, 5, 1, 2, 0);
    go(); bus.in_inst = enc(4, 6, 5, 0, 0); mid();
    chk("raw_mul_valid", bus.out_valid, 1);
    chk("raw_in_ready", bus.in_ready, 1);
    go(); bus.in_valid = 1'b0; mid();
    chk("raw_stall", bus.out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      go(); mid();
      chk("raw_hold", bus.out_valid, 0);
    end
    wb_valid = 1'b1; wb_dst = 5'd5;
    chk("raw_no_bypass", bus.out_valid, 0);
    go(); wb_valid = 1'b0; mid();
    chk("raw_release", bus.out_valid, 1);
    chk("raw_op", bus.out_opcode, 4);
    chk("raw_src1", bus.out_src1, 5);
    go(); mid();
    chk("raw_pending", pending_count, 1);

    // Immediate sign extension and mask capture ordering
    do_reset();
    bus.in_valid = 1'b1; bus.in_inst = enc(0, 1, 2, 3, 'h1FFF);
    mask_wr = 1'b1; mask_in = 8'h0F;
    go(); mask_wr = 1'b0; bus.in_inst = enc(6, 0, 4, 5, 'h0FFF); mid();
    chk("imm_neg", bus.out_imm, 32'hFFFFFFFF);
    chk("mask_old", bus.out_mask, 8'hFF);
    chk("mask_in_ready", bus.in_ready, 1);
    go(); bus.in_valid = 1'b0; mid();
    chk("store_valid", bus.out_valid, 1);
    chk("store_op", bus.out_opcode, 6);
    chk("imm_pos", bus.out_imm, 32'h00000FFF);
    chk("mask_new", bus.out_mask, 8'h0F);

    // In-flight limit: four writers, a STORE, then a stalled fifth writer
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      bus.in_valid = 1'b1; bus.in_inst = enc(0, r, 0, 0, 0);
      go();
    end
    bus.in_inst = enc(6, 0, 10, 11, 0);
    go();
    bus.in_inst = enc(1, 8, 0, 0, 0); mid();
    chk("lim_pending4", pending_count, 4);
    chk("lim_store_issues", bus.out_valid, 1);
    go(); bus.in_valid = 1'b0; mid();
    chk("lim_stall0", bus.out_valid, 0);
    go(); mid();
    chk("lim_stall1", bus.out_valid, 0);
    chk("lim_pending_hold", pending_count, 4);
    wb_valid = 1'b1; wb_dst = 5'd2;
    go(); wb_valid = 1'b0; mid();
    chk("lim_release", bus.out_valid, 1);
    chk("lim_release_dst", bus.out_dst, 8);
    chk("lim_pending3", pending_count, 3);
    go(); mid();
    chk("lim_pending_back", pending_count, 4);

    // Illegal opcode: consumed, sticky error until reset
    do_reset();
    bus.in_valid = 1'b1; bus.in_inst = enc(9, 1, 2, 3, 0); mid();
    chk("ill_in_ready", bus.in_ready, 1);
    go(); bus.in_valid = 1'b0; mid();
    chk("ill_err", err_illegal, 1);
    chk("ill_no_issue", bus.out_valid, 0);
    chk("ill_busy", busy, 0);
    send(enc(0, 1, 2, 3, 0)); mid();
    chk("ill_legal_flows", bus.out_valid, 1);
    go(); go(); mid();
    chk("ill_sticky", err_illegal, 1);
    do_reset(); mid();
    chk("ill_cleared", err_illegal, 0);

    // Flush with a stalled held instruction and two writes in flight
    do_reset();
    mask_wr = 1'b1; mask_in = 8'h3C;
    go(); mask_wr = 1'b0;
    bus.in_valid = 1'b1; bus.in_inst = enc(0, 1, 0, 0, 0); go();
    bus.in_inst = enc(0, 2, 0, 0, 0); go();
    bus.in_inst = enc(4, 3, 1, 0, 0); go();
    bus.in_valid = 1'b0; mid();
    chk("fl_pre_pending", pending_count, 2);
    chk("fl_pre_stall", bus.out_valid, 0);
    flush = 1'b1;
    go(); flush = 1'b0; mid();
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_pending", pending_count, 0);
    chk("fl_busy", busy, 0);
    send(enc(0, 9, 0, 0, 0)); mid();
    chk("fl_mask_kept", bus.out_mask, 8'h3C);
    go();
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_inst = enc(0, 10, 0, 0, 0); mid();
    chk("fl_in_ready", bus.in_ready, 0);
    go(); flush = 1'b0; bus.in_valid = 1'b0; mid();
    chk("fl_not_accepted", bus.out_valid, 0);
    chk("fl_pending2", pending_count, 0);

    // Issue-set and writeback of the same register in one cycle
    do_reset();
    send(enc(0, 2, 0, 0, 0)); go();
    bus.in_valid = 1'b1; bus.in_inst = enc(0, 7, 0, 0, 0);
    go(); bus.in_valid = 1'b0; wb_valid = 1'b1; wb_dst = 5'd7; mid();
    chk("sim_valid", bus.out_valid, 1);
    chk("sim_pre_pending", pending_count, 1);
    go(); wb_valid = 1'b0; mid();
    chk("sim_pending", pending_count, 1);
    send(enc(0, 7, 0, 0, 0)); mid();
    chk("sim_sb7_set", bus.out_valid, 0);
    wb_valid = 1'b1; wb_dst = 5'd7;
    go(); wb_valid = 1'b0; mid();
    chk("sim_sb7_release", bus.out_valid, 1);

    // Decode table, each from an idle pipeline
    do_reset();
    err_exp = 1'b0;
    foreach (vt[i]) begin
      send(vt[i].inst); mid();
      chk("tbl_valid", bus.out_valid, vt[i].legal);
      if (vt[i].legal) begin
        chk("tbl_op", bus.out_opcode, vt[i].op);
        chk("tbl_dst", bus.out_dst, vt[i].dst);
        chk("tbl_src1", bus.out_src1, vt[i].s1);
        chk("tbl_src2", bus.out_src2, vt[i].s2);
        chk("tbl_imm", bus.out_imm, vt[i].imm);
      end
      err_exp = err_exp | !vt[i].legal;
      chk("tbl_err", err_illegal, err_exp);
      go(); mid();
      chk("tbl_pending", pending_count, vt[i].wr);
      if (vt[i].wr) begin
        wb_valid = 1'b1; wb_dst = vt[i].dst;
        go(); wb_valid = 1'b0;
      end
    end

    // Randomized run against the reference model
    do_reset();
    m_hv = 0; m_pend = 0; m_err = 0; m_mask = '1; m_cmask = '0;
    m_op = 0; m_dst = 0; m_s1 = 0; m_s2 = 0; m_imm = '0;
    foreach (m_sb[i]) m_sb[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r_op, r_d, r_s1, r_s2, r_imm, sx;
      bit m_ov, m_ir, issue, accept, set, clr;
      r_op  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(7, 15)) : int'($urandom_range(0, 6));
      r_d   = $urandom_range(0, 7);
      r_s1  = $urandom_range(0, 7);
      r_s2  = $urandom_range(0, 7);
      r_imm = $urandom_range(0, 8191);
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in_inst   = enc(r_op, r_d, r_s1, r_s2, r_imm);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      mask_wr       = ($urandom_range(0, 7) == 0);
      mask_in       = NL'($urandom);
      wb_valid      = ($urandom_range(0, 2) == 0);
      wb_dst        = 5'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 63) == 0);

      m_ov = m_hv && !m_hazard();
      m_ir = !flush && (!m_hv || (m_ov && bus.out_ready));
      mid();
      chk("rnd_in_ready", bus.in_ready, m_ir);
      chk("rnd_out_valid", bus.out_valid, m_ov);
      chk("rnd_pending", pending_count, m_pend);
      chk("rnd_busy", busy, m_hv || m_pend != 0);
      chk("rnd_err", err_illegal, m_err);
      if (m_ov) begin
        chk("rnd_op", bus.out_opcode, m_op);
        chk("rnd_dst", bus.out_dst, m_dst);
        chk("rnd_src1", bus.out_src1, m_s1);
        chk("rnd_src2", bus.out_src2, m_s2);
        chk("rnd_imm", bus.out_imm, m_imm);
        chk("rnd_mask", bus.out_mask, m_cmask);
      end

      issue  = m_ov && bus.out_ready;
      accept = bus.in_valid && m_ir;
      if (accept && r_op >= 7) m_err = 1;
      if (flush) begin
        m_hv = 0; m_pend = 0;
        foreach (m_sb[i]) m_sb[i] = 0;
      end else begin
        set = issue && m_writer(m_op);
        clr = wb_valid && (m_sb[wb_dst] || (set && int'(wb_dst) == m_dst));
        if (clr) m_sb[wb_dst] = 0;
        if (set) m_sb[m_dst] = 1;
        m_pend = m_pend + int'(set) - int'(clr);
        if (m_pend < 0) m_pend = 0;
        if (issue) m_hv = 0;
        if (accept && r_op < 7) begin
          m_hv = 1; m_op = r_op; m_dst = r_d; m_s1 = r_s1; m_s2 = r_s2;
          sx = (r_imm >= 4096) ? r_imm - 8192 : r_imm;
          m_imm = 32'(sx);
          m_cmask = m_mask;
        end
      end
      if (mask_wr) m_mask = mask_in;
      go();
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/warp_issue_unit.md
# warp_issue_unit

Parametrised decode-and-issue stage for the Warp Engine: accepts 32-bit warp instructions over a valid/ready handshake, decodes the fixed field format, tracks outstanding register writes in a per-register scoreboard, and issues hazard-free instructions, each tagged with the current lane mask, to the lane ALU array. It sits between the instruction FIFO and the lane datapath. It generalises the static decode functions with configurable lane count, register count and in-flight limit, plus RAW/WAW stalling, illegal-opcode trapping and flush.

## Interface
- NUM_LANES, 8, lanes driven by one issued instruction; width of the lane mask.
- DATA_WIDTH, 32, width of the sign-extended immediate.
- REG_FILE_SIZE, 32, architectural registers; power of two, 2..32.
- MAX_PENDING, 4, maximum outstanding register writes, 1..REG_FILE_SIZE.
- PW = $clog2(MAX_PENDING+1) (derived).

- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid / in_ready  in / out  1 / 1  instruction handshake.
- in_inst  in  32  instruction: opcode[31:28], dst[27:23], src1[22:18], src2[17:13], imm[12:0].
- mask_wr  in  1  load mask_in into the lane-mask register.
- mask_in  in  NUM_LANES  new lane mask.
- out_valid / out_ready  out / in  1 / 1  issue handshake.
- out_opcode  out  4  decoded opcode.
- out_dst, out_src1, out_src2  out  5 each  register indices.
- out_imm  out  DATA_WIDTH  imm[12:0] sign-extended.
- out_mask  out  NUM_LANES  lane mask bound to this instruction.
- wb_valid  in  1  writeback retiring register wb_dst.
- wb_dst  in  5  retired register.
- flush  in  1  discard held instruction and clear scoreboard.
- err_illegal  out  1  sticky illegal-instruction flag.
- pending_count  out  PW  outstanding writes.
- busy  out  1  hold_valid OR pending_count != 0.

## Operation
- Opcode classes: ADD(0), MUL(1), MAX(3): read src1, src2, write dst. FMA(2): read src1, src2, dst; write dst. RELU(4): read src1, write dst. LOAD(5): read src1, write dst. STORE(6): read src1, src2, no write. Opcodes 7–15: illegal.
- Illegal: opcode ≥ 7, or any register index used by the class ≥ REG_FILE_SIZE. An illegal instruction is consumed on handshake, never stored or issued, and sets err_illegal on the next cycle. err_illegal clears only on reset.
- Holding register: one entry (hold_valid plus decoded fields plus the captured mask). A legal instruction is captured on in_valid && in_ready.
- Hazard: a register read by the class has its scoreboard bit set (RAW); or the dst of a writer is set (WAW); or the instruction is a writer and pending_count == MAX_PENDING.
- out_valid = hold_valid && !hazard. in_ready = !hold_valid || (out_valid && out_ready).
- On issue (out_valid && out_ready) of a writer: set sb[dst] and increment pending_count.
- On wb_valid with sb[wb_dst] = 1: clear the bit and decrement the count. A wb to a clear bit, or with wb_dst ≥ REG_FILE_SIZE, is ignored.
- Same cycle issue-set and wb-clear of the same register: the bit ends set; the count is unchanged. Set and clear of different registers: both apply; the count is unchanged.
- Lane mask register: reset value all ones; loaded on mask_wr. An instruction accepted in the same cycle as mask_wr captures the old mask. An all-zero mask is issued normally.
- flush: next cycle hold_valid = 0, scoreboard = 0, pending_count = 0. in_ready is 0 during the flush cycle. Mask and err_illegal are preserved. Priority: reset > flush > normal operation.

## Timing
- Reset values: hold_valid 0, out_valid 0, in_ready 1, scoreboard 0, pending_count 0, busy 0, err_illegal 0, lane mask all ones, all out_* data 0.
- Latency: an instruction accepted in cycle N is presented with out_valid in cycle N+1 at the earliest. Sustained throughput is 1 instruction per cycle when no hazards occur.
- The scoreboard is registered. A wb in cycle N unblocks a dependent held instruction in cycle N+1; there is no same-cycle bypass.
- out_* fields are stable while out_valid = 1 and out_ready = 0. out_valid never drops without a handshake except on flush or reset.
- err_illegal asserts in the cycle after the illegal handshake.

## Test plan
- Reset, then ADD r3,r1,r2 (0x01844000) with out_ready=1 → out_valid in cycle 2, opcode 0, dst 3, src1 1, src2 2, imm 0, mask 0xFF; sb[3]=1, pending_count=1.
- RAW: issue MUL r5←r1,r2, then RELU r6←r5 → RELU is held until wb_valid/wb_dst=5; it issues exactly one cycle after the wb.
- Immediate and mask: imm field 0x1FFF → out_imm 0xFFFFFFFF. mask_wr=1, mask_in=0x0F in the same cycle as acceptance → out_mask 0xFF; the next instruction gets 0x0F.
- Limit: four writers to r1–r4 with no wb → a fifth writer is stalled and pending_count=4. A STORE is not stalled by the limit alone. One wb → the writer issues the next cycle.
- Illegal: opcode 9 → in_ready stays 1, no issue, err_illegal=1 the next cycle and held through further legal traffic until reset.
- Flush with a held stalled instruction and pending=2 → next cycle out_valid=0, pending_count=0, busy=0, mask unchanged. Simultaneous issue-set and wb of r7 → sb[7]=1 and the count is unchanged.
